// File: rtl/llatch_bank.sv
// Clocked bank of level-sensitive latch emulators with per-lane gate polarity and glitch filter.
// Define LLATCH_BANK_FILTER_EN to enable the gate filter (run counters and ARMING state).
module llatch_bank #(
    parameter int unsigned         WIDTH    = 8,
    parameter int unsigned         CHANNELS = 4,
    parameter logic [CHANNELS-1:0] G_POL    = '1,
    parameter int unsigned         FILTER   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       g,
    input  logic [CHANNELS-1:0]       e,
    input  logic [CHANNELS-1:0]       clr_n,
    input  logic [CHANNELS-1:0]       set_n,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       open,
    output logic [CHANNELS-1:0]       chg
);

    localparam logic [1:0] ST_CLOSED = 2'd0;
    localparam logic [1:0] ST_OPEN   = 2'd2;
`ifdef LLATCH_BANK_FILTER_EN
    localparam logic [1:0] ST_ARMING = 2'd1;
    localparam int unsigned FilterEff = FILTER;
    localparam int unsigned RunW      = $clog2(FILTER + 2);
    localparam logic [RunW-1:0] RunMax = RunW'(FILTER + 1);
`else
    // Filter disabled: the configured FILTER collapses to zero.
    localparam int unsigned FilterEff = FILTER * 0;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic             ga;
        logic             transp;
        logic [1:0]       state_q, state_d;
        logic [WIDTH-1:0] q_q, q_d;
        logic             chg_q;

        assign ga = g[c] ~^ G_POL[c];

`ifdef LLATCH_BANK_FILTER_EN
        logic [RunW-1:0] run_q, run_d;

        always_comb begin
            run_d = '0;
            if (ga) begin
                run_d = (run_q == RunMax) ? run_q : run_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                run_q <= '0;
            end else begin
                run_q <= run_d;
            end
        end

        // run+1 >= FILTER+1 reduces to run >= FILTER.
        assign transp = ga && (run_q >= RunMax - 1'b1);
`else
        assign transp = ga && (FilterEff == 0);
`endif

        always_comb begin
            state_d = state_q;
            case (state_q)
`ifdef LLATCH_BANK_FILTER_EN
                ST_CLOSED: begin
                    if (transp) begin
                        state_d = ST_OPEN;
                    end else if (ga) begin
                        state_d = ST_ARMING;
                    end
                end
                ST_ARMING: begin
                    if (!ga) begin
                        state_d = ST_CLOSED;
                    end else if (transp) begin
                        state_d = ST_OPEN;
                    end
                end
`else
                ST_CLOSED: begin
                    if (transp) begin
                        state_d = ST_OPEN;
                    end
                end
`endif
                ST_OPEN: begin
                    if (!ga) begin
                        state_d = ST_CLOSED;
                    end
                end
                default: state_d = ST_CLOSED;
            endcase
        end

        always_comb begin
            if (!clr_n[c]) begin
                q_d = '0;
            end else if (!set_n[c]) begin
                q_d = '1;
            end else if (transp && e[c]) begin
                q_d = d[c*WIDTH +: WIDTH];
            end else begin
                q_d = q_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_CLOSED;
                q_q     <= '0;
                chg_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                q_q     <= q_d;
                chg_q   <= (q_d != q_q);
            end
        end

        assign q[c*WIDTH +: WIDTH] = q_q;
        assign open[c]             = (state_q == ST_OPEN);
        assign chg[c]              = chg_q;
    end

endmodule

// File: tb/tb_llatch_bank.sv
// Self-checking bench for llatch_bank: directed scenarios plus randomized traffic
// checked against a per-lane behavioural model.
module tb_llatch_bank;

    localparam int W    = 8;
    localparam int C    = 4;
    localparam int FILT = 2;
    localparam logic [C-1:0] GP = 4'b1101;
`ifdef LLATCH_BANK_FILTER_EN
    localparam int F = FILT;
`else
    localparam int F = 0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [C*W-1:0] d     = '0;
    logic [C-1:0]   g     = ~GP;
    logic [C-1:0]   e     = '1;
    logic [C-1:0]   clr_n = '1;
    logic [C-1:0]   set_n = '1;
    logic [C*W-1:0] q;
    logic [C-1:0]   open;
    logic [C-1:0]   chg;

    int errors = 0;
    int checks = 0;

    // Model: count of consecutive active gate samples, latched value, last-edge flags.
    int           cnt [C];
    logic [W-1:0] mq  [C];
    logic [C-1:0] mopen;
    logic [C-1:0] mchg;

    llatch_bank #(
        .WIDTH   (W),
        .CHANNELS(C),
        .G_POL   (GP),
        .FILTER  (FILT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (d),
        .g    (g),
        .e    (e),
        .clr_n(clr_n),
        .set_n(set_n),
        .q    (q),
        .open (open),
        .chg  (chg)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            cnt[c] = 0;
            mq[c]  = '0;
        end
        mopen = '0;
        mchg  = '0;
    endtask

    function automatic logic [C*W-1:0] model_q();
        logic [C*W-1:0] v;
        for (int c = 0; c < C; c++) v[c*W +: W] = mq[c];
        return v;
    endfunction

    // Advance the model on the current inputs, then let the DUT take the same edge.
    task automatic tick();
        if (rst_n) begin
            for (int c = 0; c < C; c++) begin
                logic         ga;
                logic         trans;
                logic [W-1:0] nq;
                ga    = (g[c] == GP[c]);
                trans = ga && (cnt[c] >= F);
                cnt[c] = ga ? cnt[c] + 1 : 0;
                if (!clr_n[c])            nq = '0;
                else if (!set_n[c])       nq = '1;
                else if (trans && e[c])   nq = d[c*W +: W];
                else                      nq = mq[c];
                mchg[c]  = (nq != mq[c]);
                mq[c]    = nq;
                mopen[c] = trans;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (q !== '0) begin errors++; $display("FAIL reset_q: got %h want 0", q); end
        checks++;
        if (open !== '0) begin errors++; $display("FAIL reset_open: got %b want 0", open); end
        checks++;
        if (chg !== '0) begin errors++; $display("FAIL reset_chg: got %b want 0", chg); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_open();
        d[7:0] = 8'hA5;
        g[0]   = GP[0];
        for (int i = 0; i <= F + 1; i++) begin
            tick();
            checks++;
            if (open[0] !== (i >= F)) begin
                errors++; $display("FAIL basic_open[%0d]: got %b want %b", i, open[0], i >= F);
            end
            checks++;
            if (q[7:0] !== ((i >= F) ? 8'hA5 : 8'h00)) begin
                errors++; $display("FAIL basic_q[%0d]: got %h", i, q[7:0]);
            end
            checks++;
            if (chg[0] !== (i == F)) begin
                errors++; $display("FAIL basic_chg[%0d]: got %b want %b", i, chg[0], i == F);
            end
        end
        d[7:0] = 8'h3E;
        g[0]   = ~GP[0];
        tick();
        checks++;
        if (open[0] !== 1'b0 || q[7:0] !== 8'hA5) begin
            errors++; $display("FAIL close: got open=%b q=%h want 0/a5", open[0], q[7:0]);
        end
    endtask

    task automatic test_glitch();
`ifdef LLATCH_BANK_FILTER_EN
        clr_n[0] = 1'b0;
        tick();
        clr_n[0] = 1'b1;
        d[7:0]   = 8'h77;
        for (int i = 0; i < F + 2; i++) begin
            g[0] = (i < F) ? GP[0] : ~GP[0];
            tick();
            checks++;
            if (q[7:0] !== 8'h00 || open[0] !== 1'b0 || chg[0] !== 1'b0) begin
                errors++;
                $display("FAIL glitch[%0d]: got q=%h open=%b chg=%b want 0/0/0",
                         i, q[7:0], open[0], chg[0]);
            end
        end
`endif
    endtask

    task automatic test_neg_polarity();
        d[15:8] = 8'h01;
        g[1]    = GP[1];
        for (int i = 0; i < F; i++) tick();
        for (int v = 1; v <= 3; v++) begin
            d[15:8] = 8'(v);
            tick();
            checks++;
            if (q[15:8] !== 8'(v)) begin
                errors++; $display("FAIL neg_follow: got %h want %h", q[15:8], 8'(v));
            end
        end
        g[1]    = ~GP[1];
        d[15:8] = 8'h44;
        tick();
        checks++;
        if (q[15:8] !== 8'h03 || open[1] !== 1'b0) begin
            errors++; $display("FAIL neg_freeze: got q=%h open=%b want 03/0", q[15:8], open[1]);
        end
    endtask

    task automatic test_priority();
        d[23:16] = 8'h5A;
        g[2]     = GP[2];
        for (int i = 0; i <= F; i++) tick();
        checks++;
        if (q[23:16] !== 8'h5A || open[2] !== 1'b1) begin
            errors++; $display("FAIL prio_open: got q=%h open=%b want 5a/1", q[23:16], open[2]);
        end
        clr_n[2] = 1'b0;
        set_n[2] = 1'b0;
        tick();
        checks++;
        if (q[23:16] !== 8'h00 || chg[2] !== 1'b1 || open[2] !== 1'b1) begin
            errors++; $display("FAIL prio_clr: got q=%h chg=%b open=%b want 00/1/1",
                               q[23:16], chg[2], open[2]);
        end
        clr_n[2] = 1'b1;
        tick();
        checks++;
        if (q[23:16] !== 8'hFF) begin
            errors++; $display("FAIL prio_set: got %h want ff", q[23:16]);
        end
        set_n[2] = 1'b1;
        tick();
        checks++;
        if (q[23:16] !== 8'h5A) begin
            errors++; $display("FAIL prio_reload: got %h want 5a", q[23:16]);
        end
        g[2] = ~GP[2];
        tick();
    endtask

    task automatic test_enable();
        d[31:24] = 8'h11;
        g[3]     = GP[3];
        for (int i = 0; i <= F; i++) tick();
        e[3]     = 1'b0;
        d[31:24] = 8'h3C;
        tick();
        checks++;
        if (q[31:24] !== 8'h11 || open[3] !== 1'b1 || chg[3] !== 1'b0) begin
            errors++; $display("FAIL en_hold: got q=%h open=%b chg=%b want 11/1/0",
                               q[31:24], open[3], chg[3]);
        end
        e[3] = 1'b1;
        tick();
        checks++;
        if (q[31:24] !== 8'h3C || chg[3] !== 1'b1) begin
            errors++; $display("FAIL en_load: got q=%h chg=%b want 3c/1", q[31:24], chg[3]);
        end
        g[3] = ~GP[3];
        tick();
    endtask

    task automatic test_async_reset();
        d[7:0] = 8'h99;
        g[0]   = GP[0];
        for (int i = 0; i <= F; i++) tick();
        checks++;
        if (q[7:0] !== 8'h99) begin
            errors++; $display("FAIL areset_pre: got %h want 99", q[7:0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q !== '0 || open !== '0 || chg !== '0) begin
            errors++; $display("FAIL areset_now: got q=%h open=%b chg=%b want 0", q, open, chg);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i <= F; i++) begin
            tick();
            checks++;
            if (open[0] !== (i == F) || q[7:0] !== ((i == F) ? 8'h99 : 8'h00)) begin
                errors++; $display("FAIL areset_reopen[%0d]: got open=%b q=%h", i, open[0], q[7:0]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            d = $urandom;
            for (int c = 0; c < C; c++) begin
                if ($urandom_range(0, 3) == 0) g[c] = ~g[c];
                e[c]     = ($urandom_range(0, 4) != 0);
                clr_n[c] = ($urandom_range(0, 9) != 0);
                set_n[c] = ($urandom_range(0, 9) != 0);
            end
            tick();
            checks++;
            if (q !== model_q()) begin
                errors++; $display("FAIL rand_q[%0d]: got %h want %h", n, q, model_q());
            end
            checks++;
            if (open !== mopen) begin
                errors++; $display("FAIL rand_open[%0d]: got %b want %b", n, open, mopen);
            end
            checks++;
            if (chg !== mchg) begin
                errors++; $display("FAIL rand_chg[%0d]: got %b want %b", n, chg, mchg);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_open();
        test_glitch();
        test_neg_polarity();
        test_priority();
        test_enable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
